// File: rtl/hilo_mult_unit_pkg.sv
// rtl/hilo_mult_unit_pkg.sv - shared encodings and sizing helpers for the HI/LO result stage
//
// Purpose:
//   Common definitions used by hilo_mult_unit and its testbench:
//     - op encodings presented by the control unit on op[1:0]
//     - the two-state sequencing enum
//     - the latency counter width, derived from the multiplier latency
//
// Ports: none (package).

package hilo_mult_unit_pkg;

  // Control-unit op encodings. op[1]=0 selects a multiply, op[1]=1 a move.
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // The counter must hold the values 0..MUL_LAT inclusive, and is never
  // narrower than one bit.
  function automatic int cnt_width(input int mul_lat);
    int w;
    w = $clog2(mul_lat + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/hilo_mult_unit_sign_fix.sv
// rtl/hilo_mult_unit_sign_fix.sv - operand magnitude and product negate for signed MULT
//
// Purpose:
//   Combinational helper for the signed multiply path. The external multiplier
//   is unsigned, so signed operands are reduced to magnitudes before issue and
//   the unsigned product is negated afterwards when the operand signs differ.
//
// Ports:
//   a, b           in  32  raw operands (two's complement)
//   a_abs, b_abs   out 32  magnitudes; 0x80000000 maps to itself, which is the
//                          correct unsigned magnitude of -2^31
//   sign_mismatch  out 1   a[31] ^ b[31]; result must be negated
//   neg            in  1   registered negate request for the product in flight
//   prod_in        in  64  unsigned product from the multiplier
//   prod_out       out 64  prod_in, or its 64-bit two's-complement negation

module mult_sign_fix (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] a_abs,
  output logic [31:0] b_abs,
  output logic        sign_mismatch,
  input  logic        neg,
  input  logic [63:0] prod_in,
  output logic [63:0] prod_out
);

  always_comb begin
    a_abs         = a[31] ? (~a + 32'd1) : a;
    b_abs         = b[31] ? (~b + 32'd1) : b;
    sign_mismatch = a[31] ^ b[31];
    // Wraps modulo 2^64; a zero product stays zero.
    prod_out      = neg ? (~prod_in + 64'd1) : prod_in;
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - HI/LO result stage around an external shift-add multiplier
//
// Purpose:
//   Accepts MULT/MULTU/MTHI/MTLO requests from the control FSM, drives the
//   registered operands of an external unsigned multiplier, waits its fixed
//   latency, and commits the 64-bit product into HI/LO. busy is the interlock
//   the controller uses to stall MFHI/MFLO; done pulses for one cycle after
//   every HI/LO write.
//
// Configuration:
//   SIGNED_MULT_EN  defined   : op=MULT multiplies magnitudes and negates the
//                               product when the operand signs differ.
//                   undefined : op=MULT behaves exactly like MULTU; no sign
//                               logic and no neg flop are built.
//
// Parameters:
//   MUL_LAT  edges from the first edge the multiplier sees stable operands
//            until mul_z is valid (>= 1).
//
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-high reset
//   start  in  1   request strobe, only sampled while busy=0
//   op     in  2   00 MULTU, 01 MULT, 10 MTHI, 11 MTLO
//   rs     in  32  first operand / MTHI-MTLO source
//   rt     in  32  second operand
//   busy   out 1   multiply in flight
//   done   out 1   one-cycle pulse the cycle after HI/LO change
//   hi     out 32  HI register
//   lo     out 32  LO register
//   mul_a  out 32  registered multiplier operand a
//   mul_b  out 32  registered multiplier operand b
//   mul_z  in  64  multiplier product

module hilo_mult_unit #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z
);

  import hilo_mult_unit_pkg::*;

  localparam int            CW       = cnt_width(MUL_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        done_q, done_d;

  // Operands as they should be issued, and the product as it should commit.
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [63:0] prod_fixed;

  // A multiply is accepted only from IDLE; requests while busy are dropped.
  logic accept_mul;
  assign accept_mul = (state_q == IDLE) && start && !op[1];

`ifdef SIGNED_MULT_EN
  logic        neg_q, neg_d;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic        sign_mismatch;
  logic        is_signed;

  mult_sign_fix u_sign_fix (
    .a             (rs),
    .b             (rt),
    .a_abs         (rs_abs),
    .b_abs         (rt_abs),
    .sign_mismatch (sign_mismatch),
    .neg           (neg_q),
    .prod_in       (mul_z),
    .prod_out      (prod_fixed)
  );

  always_comb begin
    is_signed = (op == OP_MULT);
    issue_a   = is_signed ? rs_abs : rs;
    issue_b   = is_signed ? rt_abs : rt;
    // neg is captured with the operands and held for the whole WAIT.
    neg_d     = neg_q;
    if (accept_mul) begin
      neg_d = is_signed && sign_mismatch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  // Unsigned-only build: MULT is issued exactly like MULTU.
  always_comb begin
    issue_a    = rs;
    issue_b    = rt;
    prod_fixed = mul_z;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: begin
              hi_d   = rs;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = rs;
              done_d = 1'b1;
            end
            default: begin
              mul_a_d = issue_a;
              mul_b_d = issue_b;
              cnt_d   = '0;
              state_d = WAIT;
            end
          endcase
        end
      end

      WAIT: begin
        // cnt equals the number of edges the multiplier has seen the
        // operands; at MUL_LAT the product on mul_z is valid.
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = prod_fixed;
          done_d       = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == WAIT);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - self-checking bench for hilo_mult_unit

module tb_hilo_mult_unit;

  localparam int MUL_LAT = 1;
  localparam logic [1:0] C_MULTU = 2'b00;
  localparam logic [1:0] C_MULT  = 2'b01;
  localparam logic [1:0] C_MTHI  = 2'b10;
  localparam logic [1:0] C_MTLO  = 2'b11;

  logic        clk;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] rs    = '0;
  logic [31:0] rt    = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;

  int checks = 0;
  int errors = 0;

  hilo_mult_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_z (mul_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unsigned multiplier: product registered MUL_LAT edges deep.
  logic [63:0] pipe [MUL_LAT];
  always @(posedge clk) begin
    pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end
  assign mul_z = pipe[MUL_LAT-1];

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  res_t        sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
`ifdef SIGNED_MULT_EN
    if (o == C_MULT) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
    end
`else
    sa = '0;
    sb = '0;
    if (o == C_MULT) p = p + 64'(sa) + 64'(sb);
`endif
    return p;
  endfunction

  function automatic logic [31:0] exp_opnd(input logic [1:0] o, input logic [31:0] x);
`ifdef SIGNED_MULT_EN
    if (o == C_MULT && x[31]) return 32'd0 - x;
`endif
    if (o == 2'b11) return x;
    return x;
  endfunction

  // Drives one request, pushes its expected HI/LO, waits (bounded) for done,
  // and scores latency, operands, result and the single-cycle done pulse.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi,
                       input logic [31:0] elo, input bit inject_mtlo);
    res_t        e;
    int          n;
    bit          is_mul;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    is_mul  = !o[1];
    prev_hi = hi;
    prev_lo = lo;
    sb_q.push_back('{hi: ehi, lo: elo});
    m_hi  = ehi;
    m_lo  = elo;
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs    = $urandom;
    rt    = $urandom;
    if (is_mul) begin
      check({tag, " busy after accept"}, 64'(busy), 64'd1);
      check({tag, " mul_a"}, 64'(mul_a), 64'(exp_opnd(o, a)));
      check({tag, " mul_b"}, 64'(mul_b), 64'(exp_opnd(o, b)));
      check({tag, " hi/lo held while busy"}, {hi, lo}, {prev_hi, prev_lo});
    end else begin
      check({tag, " busy stays low"}, 64'(busy), 64'd0);
    end
    n = 0;
    while (!done && n < 40) begin
      if (inject_mtlo && n == 0) begin
        start = 1'b1;
        op    = C_MTLO;
        rs    = 32'hdead_beef;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check({tag, " edges to commit"}, 64'(n), is_mul ? 64'(MUL_LAT + 1) : 64'd0);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " hi"}, 64'(hi), 64'(e.hi));
      check({tag, " lo"}, 64'(lo), 64'(e.lo));
    end
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] p;
    int          n;
    int          dcnt;

    vecs[0] = '{C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
`ifdef SIGNED_MULT_EN
    vecs[1] = '{C_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[4] = '{C_MULT, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
`else
    vecs[1] = '{C_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1};
    vecs[4] = '{C_MULT, 32'd7, 32'hFFFF_FFFF, 32'h0000_0006, 32'hFFFF_FFF9};
`endif
    vecs[2] = '{C_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{C_MULT, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{C_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset mul_a", 64'(mul_a), 64'd0);
    check("reset mul_b", 64'(mul_b), 64'd0);
    check("idle busy", 64'(busy), 64'd0);
    check("idle done", 64'(done), 64'd0);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
            vecs[i].ehi, vecs[i].elo, 1'b0);
    end

    // Random multiplies scored against the reference product.
    for (int i = 0; i < 8; i++) begin
      ro = (($urandom & 1) != 0) ? C_MULT : C_MULTU;
      ra = $urandom;
      rb = $urandom;
      p  = model_prod(ro, ra, rb);
      do_op($sformatf("rnd%0d", i), ro, ra, rb, p[63:32], p[31:0], 1'b0);
    end

    // MTHI leaves LO alone; MTLO during a multiply is dropped.
    do_op("mthi", C_MTHI, 32'h0000_1234, 32'h0, 32'h0000_1234, m_lo, 1'b0);
    do_op("mtlo", C_MTLO, 32'hCAFE_0001, 32'h0, m_hi, 32'hCAFE_0001, 1'b0);
    do_op("multu_inject", C_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);

    // A new request is accepted in the same cycle done is high.
    op = C_MULTU; rs = 32'd3; rt = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b mul edges", 64'(n), 64'(MUL_LAT + 1));
    op = C_MTHI; rs = 32'h0000_0055; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b hi", 64'(hi), 64'h55);
    check("b2b lo", 64'(lo), 64'd12);
    check("b2b done", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("b2b done drop", 64'(done), 64'd0);

    // Reset while a multiply is in flight.
    op = C_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort busy before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort mul_a", 64'(mul_a), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    check("abort no done", 64'(dcnt), 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    do_op("post_abort", C_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
# hilo_mult_unit

Multicycle-CPU HI/LO result stage that sits around the shift-add unsigned multiplier. It accepts MULT/MULTU/MTHI/MTLO requests from the control unit and drives the multiplier operand inputs. It waits the multiplier's fixed latency, applies the sign correction for signed MULT, and commits the 64-bit product into the architectural HI/LO registers. Its busy/done handshake is the interlock that the control FSM uses to stall MFHI/MFLO.

## Interface
- MUL_LAT, default 1: number of clock edges between the first edge the multiplier sees stable operands and `mul_z` being valid (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request strobe; sampled only when `busy`=0.
- op  in  2  00 MULTU, 01 MULT, 10 MTHI, 11 MTLO.
- rs  in  32  first operand / MTHI, MTLO source.
- rt  in  32  second operand.
- busy  out  1  multiply in flight; reset 0.
- done  out  1  one-cycle pulse, the cycle after HI/LO change; reset 0.
- hi  out  32  HI register; reset 0.
- lo  out  32  LO register; reset 0.
- mul_a  out  32  registered multiplier operand a; reset 0.
- mul_b  out  32  registered multiplier operand b; reset 0.
- mul_z  in  64  multiplier product.

## Operation
- States: IDLE, WAIT.
- IDLE with start=1 and op=MTHI: hi<=rs at that edge and lo is unchanged. done=1 next cycle. Stays in IDLE.
- IDLE with start=1 and op=MTLO: same behaviour with lo<=rs.
- IDLE with start=1 and op=MULTU: mul_a<=rs, mul_b<=rt, neg<=0, cnt<=0, and the state goes to WAIT.
- IDLE with start=1 and op=MULT (signed path): mul_a<=|rs|, mul_b<=|rt|, neg<=rs[31]^rt[31].
  - |x| is the 32-bit two's-complement negate when x[31]=1.
  - |0x80000000| = 0x80000000, which is correct as an unsigned operand.
- WAIT: cnt increments each edge. mul_a, mul_b and neg are held constant.
- On the edge where cnt==MUL_LAT:
  - {hi,lo} <= neg ? (~mul_z+1) : mul_z, using 64-bit wrap-around arithmetic.
  - The state returns to IDLE.
- busy = (state==WAIT).
- done is registered. It rises the cycle after any HI/LO write and lasts exactly one cycle.
- start while busy=1 is ignored. No queuing; the request is lost and the controller must hold it.
- hi/lo are always readable. While busy=1 they hold the previous values, and the controller stalls MFHI/MFLO on busy.
- Reset at any time, including mid-WAIT:
  - The state goes to IDLE.
  - hi, lo, mul_a, mul_b, cnt and neg are all cleared, and busy=0 and done=0.
  - No done pulse is produced for the aborted op.

## Timing
- Multiply accepted at edge E0; busy=1 from E0 to E0+MUL_LAT+1.
- HI/LO are updated at edge E0+MUL_LAT+1. busy=0 and done=1 in the cycle after that edge.
- Total multiply latency is MUL_LAT+1 edges. For the default, HI/LO update 2 edges after acceptance.
- A new start is accepted in the same cycle that done=1.
- MTHI/MTLO: 1 edge latency; busy never asserts.

## Configuration
- SIGNED_MULT_EN
  - Defined: op=01 takes the signed path (abs operands, negate product on sign mismatch).
  - Undefined: op=01 behaves identically to MULTU. No abs/negate logic is built and neg is tied 0.

## Structure
- Shared package holds:
  - the op encodings OP_MULTU, OP_MULT, OP_MTHI, OP_MTLO;
  - the state enum {IDLE, WAIT};
  - the counter width derived from MUL_LAT.
- One sub-module: `mult_sign_fix`, combinational 32-bit abs and 64-bit conditional negate. It is instantiated only under SIGNED_MULT_EN.
- The multiplier itself is external; the bench supplies a behavioural model that registers a*b with MUL_LAT delay.

## Test plan
- Reset asserted, then released: hi=lo=0, busy=0, done=0, mul_a=mul_b=0.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF: at E0+MUL_LAT+1, hi=0xFFFFFFFE and lo=0x00000001. done pulses once.
- MULT rs=0xFFFFFFFD (−3), rt=5:
  - With SIGNED_MULT_EN: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Without it: hi=0x00000004, lo=0xFFFFFFF1.
- MULT rs=0x80000000, rt=0x80000000 (macro on): hi=0x40000000, lo=0x00000000. MULT 0 × 0xFFFFFFFF gives hi=lo=0.
- Interaction with MTHI:
  - MTHI rs=0x1234 in IDLE: hi=0x1234 next edge, lo unchanged, busy stays 0.
  - Then MULTU 2×3 with a MTLO start pulsed mid-WAIT: the MTLO is ignored, and the final result is hi=0, lo=6.
- Reset mid-WAIT: busy drops immediately, hi=lo=0, and no done pulse is produced. A following MULTU 7×9 yields lo=63.
